// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bundle (sub only with SERIAL_ADDER_SUB_EN)
interface serial_adder_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub;
`endif
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic overflow;
`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, overflow);
  modport slave (input start, a, b, cin, sub, output busy, done, sum, cout, overflow);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, overflow);
  modport slave (input start, a, b, cin, output busy, done, sum, cout, overflow);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder, DIGIT bits per clock LSB first; SERIAL_ADDER_SUB_EN adds subtract mode
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic rst,
  serial_adder_if.slave bus
);
  localparam int L = WIDTH / DIGIT;
  localparam int CW = $clog2(L + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, b_lat;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, cin_lat;
  logic [DIGIT:0] dsum;
  logic cmsb, last, accept;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_lat = bus.sub ? ~bus.b : bus.b;
  assign cin_lat = bus.sub ? ~bus.cin : bus.cin;
`else
  assign b_lat = bus.b;
  assign cin_lat = bus.cin;
`endif
  assign dsum = (DIGIT+1)'(a_q[DIGIT-1:0]) + (DIGIT+1)'(b_q[DIGIT-1:0]) + (DIGIT+1)'(c_q);
  assign cmsb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
  assign last = cnt_q == CW'(L - 1);
  assign accept = bus.start && state_q != RUN;
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.overflow = ovf_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (accept) begin
      state_d = RUN;
      a_d = bus.a;
      b_d = b_lat;
      c_d = cin_lat;
      sum_d = '0;
      cnt_d = '0;
      cout_d = 1'b0;
      ovf_d = 1'b0;
    end else if (state_q == RUN) begin
      a_d = a_q >> DIGIT;
      b_d = b_q >> DIGIT;
      c_d = dsum[DIGIT];
      sum_d = WIDTH'({dsum[DIGIT-1:0], sum_q} >> DIGIT);
      cnt_d = cnt_q + CW'(1);
      state_d = last ? DONE : RUN;
      cout_d = last ? dsum[DIGIT] : cout_q;
      ovf_d = last ? dsum[DIGIT] ^ cmsb : ovf_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      sum_q <= '0;
      cnt_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: four DUTs (DIGIT 1,2,4,8) checked against an arithmetic reference model
module tb_serial_adder;
  logic clk, rst;
  logic [3:0] st;
  logic [7:0] oa, ob;
  logic ocin;
`ifdef SERIAL_ADDER_SUB_EN
  logic osub;
`endif
  logic [3:0] busy_w, done_w, cout_w, ovf_w;
  logic [7:0] sum_w [4];
  int tests, fails;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : d
    serial_adder_if #(.WIDTH(8)) bus ();
    assign bus.start = st[g];
    assign bus.a = oa;
    assign bus.b = ob;
    assign bus.cin = ocin;
`ifdef SERIAL_ADDER_SUB_EN
    assign bus.sub = osub;
`endif
    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
    assign sum_w[g] = bus.sum;
    assign cout_w[g] = bus.cout;
    assign ovf_w[g] = bus.overflow;
    serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u (.clk(clk), .rst(rst), .bus(bus));
  end
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s D%0d: observed %0h expected %0h", tag, 1 << k, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle_chk(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_busy"}, k, 32'(busy_w[k]), 0);
      chk({tag, "_done"}, k, 32'(done_w[k]), 0);
      chk({tag, "_sum"}, k, 32'(sum_w[k]), 0);
      chk({tag, "_cout"}, k, 32'(cout_w[k]), 0);
      chk({tag, "_ovf"}, k, 32'(ovf_w[k]), 0);
    end
  endtask
  task automatic op(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb, input int poke);
    logic [7:0] bm, es;
    int u, sv, cm, lk;
    logic ec, eo;
    bm = sb ? ~b : b;
    cm = sb ? int'(!ci) : int'(ci);
    u = int'(a) + int'(bm) + cm;
    es = u[7:0];
    ec = u[8];
    sv = int'($signed(a)) + int'($signed(bm)) + cm;
    eo = sv > 127 || sv < -128;
    oa = a;
    ob = b;
    ocin = ci;
`ifdef SERIAL_ADDER_SUB_EN
    osub = sb;
`endif
    st = m;
    step();
    oa = 8'($urandom);
    ob = 8'($urandom);
    ocin = 1'($urandom);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      st = '0;
      for (int k = 0; k < 4; k++) begin
        if (m[k]) begin
          lk = 8 >> k;
          chk("busy", k, 32'(busy_w[k]), 32'(c < lk));
          chk("done", k, 32'(done_w[k]), 32'(c == lk));
          if (c >= lk) begin
            chk("sum", k, 32'(sum_w[k]), 32'(es));
            chk("cout", k, 32'(cout_w[k]), 32'(ec));
            chk("ovf", k, 32'(ovf_w[k]), 32'(eo));
          end
        end
      end
      if (c == poke) begin
        for (int k = 0; k < 4; k++) st[k] = m[k] && poke < (8 >> k);
        oa = 8'($urandom);
        ob = 8'($urandom);
      end
    end
    st = '0;
  endtask
  initial begin
    tests = 0;
    fails = 0;
    clk = 0;
    rst = 1;
    st = '0;
    oa = '0;
    ob = '0;
    ocin = 0;
`ifdef SERIAL_ADDER_SUB_EN
    osub = 0;
`endif
    @(negedge clk);
    step();
    idle_chk("reset");
    rst = 0;
    step();
    op(4'b0001, 8'hFF, 8'h01, 1'b0, 1'b0, -1);
    op(4'b1100, 8'h7F, 8'h01, 1'b0, 1'b0, -1);
    op(4'b0010, 8'h3C, 8'h0F, 1'b1, 1'b0, 1);
    op(4'b0001, 8'h12, 8'h34, 1'b0, 1'b0, 5);
    oa = 8'h11;
    ob = 8'h22;
    ocin = 0;
    st = 4'b0010;
    step();
    st = '0;
    repeat (4) step();
    chk("chain_done1", 1, 32'(done_w[1]), 1);
    chk("chain_sum1", 1, 32'(sum_w[1]), 32'h33);
    oa = 8'hF0;
    ob = 8'h20;
    ocin = 1;
    st = 4'b0010;
    step();
    st = '0;
    chk("chain_busy", 1, 32'(busy_w[1]), 1);
    chk("chain_nodone", 1, 32'(done_w[1]), 0);
    chk("chain_clr", 1, 32'(sum_w[1]), 0);
    repeat (4) step();
    chk("chain_done2", 1, 32'(done_w[1]), 1);
    chk("chain_sum2", 1, 32'(sum_w[1]), 32'h11);
    chk("chain_cout2", 1, 32'(cout_w[1]), 1);
    chk("chain_ovf2", 1, 32'(ovf_w[1]), 0);
    step();
    op(4'b1110, 8'h80, 8'h80, 1'b0, 1'b0, -1);
    oa = 8'hAA;
    ob = 8'h55;
    ocin = 0;
    st = 4'b0001;
    step();
    st = '0;
    repeat (3) step();
    rst = 1;
    step();
    rst = 0;
    idle_chk("abort");
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_nodone", 0, 32'(done_w[0]), 0);
    end
    op(4'hF, 8'hAA, 8'h55, 1'b1, 1'b0, -1);
`ifdef SERIAL_ADDER_SUB_EN
    op(4'hF, 8'h05, 8'h07, 1'b0, 1'b1, -1);
    op(4'hF, 8'h80, 8'h01, 1'b0, 1'b1, -1);
`endif
    for (int i = 0; i < 1000; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      op(4'hF, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), -1);
`else
      op(4'hF, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, -1);
`endif
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
